serial_alu_ctrl: RTL and testbench
==================================

# serial_alu_ctrl

Bit-serial sequencer that drives the team's 1-bit ALU slice (`top_alu`) to perform WIDTH-bit addition or subtraction. A host loads two WIDTH-bit operands and a 3-bit operation code. The block then presents one operand bit pair per clock, LSB first, to the slice, feeding the slice's carry/borrow output back into its carry/borrow input. It reassembles the result word and the final carry/borrow, and signals completion with a one-cycle `done` pulse.

## Interface
- WIDTH, 4: operand/result width in bits; legal range 2 to 32.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  operand 1 (augend/minuend).
- B  input  WIDTH  operand 2 (addend/subtrahend).
- op  input  3  operation code passed to the slice: 3'b001 add, 3'b010 subtract, others unsupported.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when R/cb_final become valid.
- R  output  WIDTH  result word; held until the next accepted start.
- cb_final  output  1  carry (add) or borrow (subtract) out of the MSB; held with R.
- zero  output  1  high when R == 0; qualified by R validity, held with R.
- alu_in1  output  1  to slice In1.
- alu_in2  output  1  to slice In2.
- alu_cb_in  output  1  to slice CB_in.
- alu_code_op  output  3  to slice code_op.
- alu_result  input  1  from slice Result.
- alu_cb_out  input  1  from slice CB_out.

## Operation
- States: IDLE, RUN, DONE. Registers: a_sh, b_sh, r_sh (WIDTH each), op_q (3), cb_q (1), cnt (clog2(WIDTH+1) bits).
- IDLE:
  - alu_in1/alu_in2/alu_cb_in = 0 and alu_code_op = 3'b000.
  - When start = 1: load a_sh <= A, b_sh <= B, op_q <= op, cb_q <= 0, cnt <= 0, then go to RUN.
- RUN (exactly WIDTH cycles):
  - Combinational outputs: alu_in1 = a_sh[0], alu_in2 = b_sh[0], alu_cb_in = cb_q, alu_code_op = op_q.
  - Each edge: r_sh <= {alu_result, r_sh[WIDTH-1:1]}, cb_q <= alu_cb_out, a_sh and b_sh shift right by 1, cnt <= cnt + 1.
  - When cnt == WIDTH-1 at the edge: R <= final assembled word, cb_final <= alu_cb_out, go to DONE.
- DONE (1 cycle): done = 1, then go to IDLE.
- Initial carry/borrow is always 0; no carry-in from the host.
- Unsupported op is still sequenced for WIDTH cycles. The slice returns zeros, so R = 0, cb_final = 0, zero = 1.
- start while busy (RUN or DONE) is ignored and not queued. A, B and op changing while busy have no effect.
- R, cb_final and zero change only at the RUN→DONE edge and at reset.

## Timing
- Reset values: state IDLE, busy 0, done 0, R 0, cb_final 0, zero 1, all alu_* outputs 0, all internal registers 0.
- Latency:
  - start sampled high at edge t.
  - RUN occupies cycles t+1 … t+WIDTH.
  - R/cb_final are valid and done = 1 in cycle t+WIDTH+1.
  - Earliest next accepted start is at the edge ending that DONE cycle + 1, i.e. the IDLE cycle t+WIDTH+2. Throughput is one operation per WIDTH+2 cycles.
- busy rises in cycle t+1 and falls in cycle t+WIDTH+2.
- The slice is purely combinational. alu_result/alu_cb_out are sampled on the same edge that advances the shift registers, so there is no extra pipeline stage.
- rst mid-RUN: at the next edge return to IDLE with all reset values, discarding the partial result. There is no done pulse for the aborted operation.
- rst and start asserted together: reset wins and start is lost.

## Test plan
- WIDTH=4, op=001, A=5, B=3 → done in cycle t+5, R=4'b1000, cb_final=0, zero=0. Monitor the alu_in1 sequence 1,0,1,0 and alu_cb_in sequence 0,1,1,1.
- op=001, A=9, B=8 → R=4'b0001, cb_final=1. op=001, A=15, B=1 → R=0, cb_final=1, zero=1.
- op=010, A=3, B=5 → R=4'b1110, cb_final=1. op=010, A=7, B=7 → R=0, cb_final=0, zero=1.
- op=3'b100, A=12, B=6 → still WIDTH+1 cycles to done; R=0, cb_final=0, zero=1.
- Start A=5, B=3 add, then pulse start with A=1, B=1 during RUN → the second start is ignored and R=8. Previous R is held until the next accepted start completes.
- Assert rst in cycle t+2 of an operation → no done pulse, R=0, busy=0, zero=1. A fresh start afterwards completes normally with the exact WIDTH+1 latency.

Source files
------------

// File: rtl/serial_alu_ctrl_if.sv
// rtl/serial_alu_ctrl_if.sv - host request/result bundle between a host and serial_alu_ctrl
interface serial_alu_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [2:0]       op;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] R;
   logic             cb_final;
   logic             zero;

   modport master (output start, A, B, op, input busy, done, R, cb_final, zero);
   modport slave  (input start, A, B, op, output busy, done, R, cb_final, zero);
endinterface

// File: rtl/serial_alu_ctrl.sv
// rtl/serial_alu_ctrl.sv - bit-serial add/subtract sequencer around a combinational 1-bit ALU slice
module serial_alu_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   serial_alu_ctrl_if.slave host,
   output logic             alu_in1,
   output logic             alu_in2,
   output logic             alu_cb_in,
   output logic [2:0]       alu_code_op,
   input  logic             alu_result,
   input  logic             alu_cb_out
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] r_sh;
   logic [2:0]       op_q;
   logic             cb_q;
   logic [CW-1:0]    cnt;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] r_q;
   logic             cbf_q;
   logic             zero_q;
   logic [WIDTH-1:0] r_next;

   // Slice result enters at the MSB so the LSB-first stream lands in order after WIDTH shifts.
   assign r_next = {alu_result, r_sh[WIDTH-1:1]};

   assign host.busy     = busy_q;
   assign host.done     = done_q;
   assign host.R        = r_q;
   assign host.cb_final = cbf_q;
   assign host.zero     = zero_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         r_sh   <= '0;
         op_q   <= 3'b000;
         cb_q   <= 1'b0;
         cnt    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         r_q    <= '0;
         cbf_q  <= 1'b0;
         zero_q <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (host.start) begin
                  a_sh   <= host.A;
                  b_sh   <= host.B;
                  op_q   <= host.op;
                  cb_q   <= 1'b0;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               r_sh <= r_next;
               cb_q <= alu_cb_out;
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               cnt  <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
                  r_q    <= r_next;
                  cbf_q  <= alu_cb_out;
                  zero_q <= (r_next == '0);
                  done_q <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               done_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   // Slice is driven only while a word is being sequenced; otherwise it sees a quiet no-op.
   always_comb begin
      alu_in1     = 1'b0;
      alu_in2     = 1'b0;
      alu_cb_in   = 1'b0;
      alu_code_op = 3'b000;
      if (state == RUN) begin
         alu_in1     = a_sh[0];
         alu_in2     = b_sh[0];
         alu_cb_in   = cb_q;
         alu_code_op = op_q;
      end
   end
endmodule

// File: tb/tb_serial_alu_ctrl.sv
// tb/tb_serial_alu_ctrl.sv - scoreboard bench for serial_alu_ctrl with a behavioural 1-bit slice
module tb_serial_alu_ctrl;
   localparam int W = 4;

   typedef struct {
      logic [W-1:0] r;
      logic         cb;
      logic         z;
      int           due;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       alu_in1, alu_in2, alu_cb_in, alu_result, alu_cb_out;
   logic [2:0] alu_code_op;

   always #5 clk = ~clk;

   serial_alu_ctrl_if #(.WIDTH(W)) host ();

   serial_alu_ctrl #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .host        (host),
      .alu_in1     (alu_in1),
      .alu_in2     (alu_in2),
      .alu_cb_in   (alu_cb_in),
      .alu_code_op (alu_code_op),
      .alu_result  (alu_result),
      .alu_cb_out  (alu_cb_out)
   );

   // Stand-in for the 1-bit slice: full adder / full subtractor, zeros for other codes.
   always_comb begin
      alu_result = 1'b0;
      alu_cb_out = 1'b0;
      case (alu_code_op)
         3'b001: begin
            alu_result = alu_in1 ^ alu_in2 ^ alu_cb_in;
            alu_cb_out = (alu_in1 & alu_in2) | (alu_cb_in & (alu_in1 ^ alu_in2));
         end
         3'b010: begin
            alu_result = alu_in1 ^ alu_in2 ^ alu_cb_in;
            alu_cb_out = (~alu_in1 & alu_in2) | (~(alu_in1 ^ alu_in2) & alu_cb_in);
         end
         default: ;
      endcase
   end

   exp_t         sb[$];
   int           checks = 0;
   int           failures = 0;
   int           cyc = 0;
   bit           mon_en = 0;
   bit           active = 0;
   bit           junk_en = 0;
   int           cur_t = 0;
   int           next_ok = 0;
   logic [W-1:0] cur_a, cur_b;
   logic [2:0]   cur_op;
   logic [W-1:0] held_r = '0;
   logic         held_cb = 1'b0;
   logic         held_z = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [2:0] op, input int t);
      exp_t   e;
      longint m;
      longint s;
      m = longint'(1) << W;
      if (op == 3'b001) begin
         s    = longint'(a) + longint'(b);
         e.r  = W'(s % m);
         e.cb = (s >= m);
      end else if (op == 3'b010) begin
         s    = longint'(a) - longint'(b) + m;
         e.r  = W'(s % m);
         e.cb = (a < b);
      end else begin
         e.r  = '0;
         e.cb = 1'b0;
      end
      e.z   = (e.r == '0);
      e.due = t + W;
      return e;
   endfunction

   // Carry/borrow that must enter bit i: derived from the low i bits of the operands.
   function automatic logic cb_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [2:0] op, input int i);
      longint mask;
      mask = (longint'(1) << i) - 1;
      if (op == 3'b001) return ((longint'(a) & mask) + (longint'(b) & mask)) > mask;
      if (op == 3'b010) return (longint'(a) & mask) < (longint'(b) & mask);
      return 1'b0;
   endfunction

   int   k;
   logic run_m, busy_m;
   exp_t e;

   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         k      = cyc - cur_t;
         run_m  = active && k >= 0 && k < W;
         busy_m = active && k >= 0 && k <= W;
         chk("busy", host.busy, busy_m);
         if (run_m) begin
            chk("alu_in1", alu_in1, cur_a[k]);
            chk("alu_in2", alu_in2, cur_b[k]);
            chk("alu_cb_in", alu_cb_in, cb_into(cur_a, cur_b, cur_op, k));
            chk("alu_code_op", alu_code_op, cur_op);
         end else if (!busy_m) begin
            chk("alu_idle", {alu_in1, alu_in2, alu_cb_in, alu_code_op}, 0);
         end
         if (host.done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("done_edge", cyc, e.due);
               chk("R", host.R, e.r);
               chk("cb_final", host.cb_final, e.cb);
               chk("zero", host.zero, e.z);
               held_r  = e.r;
               held_cb = e.cb;
               held_z  = e.z;
            end
         end else begin
            if (sb.size() != 0 && sb[0].due <= cyc) begin
               chk("missing_done", 0, 1);
               void'(sb.pop_front());
            end
            chk("R_held", host.R, held_r);
            chk("cb_held", host.cb_final, held_cb);
            chk("zero_held", host.zero, held_z);
         end
      end
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input int gap);
      int ed;
      while (cyc + 1 < next_ok) begin
         ed = cyc + 1;
         host.start = junk_en && active && ed > cur_t && ed <= cur_t + W + 1 &&
                      ($urandom_range(0, 2) == 0);
         host.A  = W'($urandom);
         host.B  = W'($urandom);
         host.op = 3'($urandom);
         @(negedge clk);
      end
      host.start = 1'b1;
      host.A     = a;
      host.B     = b;
      host.op    = op;
      cur_t      = cyc + 1;
      cur_a      = a;
      cur_b      = b;
      cur_op     = op;
      active     = 1;
      sb.push_back(model(a, b, op, cur_t));
      next_ok    = cur_t + W + 2 + gap;
      @(negedge clk);
      host.start = 1'b0;
   endtask

   task automatic do_reset(input logic with_start);
      rst        = 1'b1;
      host.start = with_start;
      host.A     = 4'd3;
      host.B     = 4'd3;
      host.op    = 3'b001;
      sb.delete();
      active     = 0;
      held_r     = '0;
      held_cb    = 1'b0;
      held_z     = 1'b1;
      @(negedge clk);
      rst        = 1'b0;
      host.start = 1'b0;
      next_ok    = cyc + 1;
   endtask

   initial begin
      rst        = 1'b1;
      host.start = 1'b0;
      host.A     = '0;
      host.B     = '0;
      host.op    = 3'b000;
      @(negedge clk);
      @(negedge clk);
      mon_en = 1;
      @(negedge clk);
      rst     = 1'b0;
      next_ok = cyc + 1;

      issue(4'd5,  4'd3, 3'b001, 0);
      issue(4'd9,  4'd8, 3'b001, 0);
      issue(4'd15, 4'd1, 3'b001, 0);
      issue(4'd3,  4'd5, 3'b010, 0);
      issue(4'd7,  4'd7, 3'b010, 0);
      issue(4'd12, 4'd6, 3'b100, 0);

      issue(4'd5, 4'd3, 3'b001, 0);
      host.start = 1'b1;
      host.A     = 4'd1;
      host.B     = 4'd1;
      host.op    = 3'b001;
      @(negedge clk);
      host.start = 1'b0;
      issue(4'd9, 4'd9, 3'b010, 1);

      issue(4'd6, 4'd5, 3'b001, 0);
      @(negedge clk);
      do_reset(1'b0);
      repeat (W + 3) @(negedge clk);
      do_reset(1'b1);
      repeat (2) @(negedge clk);
      issue(4'd2, 4'd3, 3'b001, 0);

      junk_en = 1;
      for (int n = 0; n < 40; n++) begin
         int sel;
         logic [2:0] rop;
         sel = $urandom_range(0, 9);
         rop = (sel < 4) ? 3'b001 : (sel < 8) ? 3'b010 : 3'($urandom);
         issue(W'($urandom), W'($urandom), rop, $urandom_range(0, 2));
      end

      host.start = 1'b0;
      repeat (W + 4) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end
endmodule
